// File: rtl/div_ctrl.sv
// div_ctrl: sequencer between the execute stage and the 33-cycle iterative
// divider. Accepts one DIV/DIVU request at a time, latches its operands,
// holds the divider start line high until completion, then returns the
// quotient/remainder through a valid/ready handshake. Divide-by-zero is
// answered directly without running the divider. A flush cancels any
// in-flight operation or pending result. A watchdog aborts a run that never
// completes and returns an error result.
//
// Ports:
//   div_clk, reset              clock, synchronous active-low reset
//   req_valid/req_ready         request handshake (req_signed, req_x, req_y)
//   flush                       cancel in-flight op / pending result
//   div_start, div_signed_o,
//   div_x, div_y                to divider (latched, stable through RUN)
//   div_s, div_r, div_complete  from divider
//   res_valid/res_ready         result handshake (res_quo, res_rem, res_err)
//   busy                        controller not idle
//
// TIMEOUT must be > 34 and <= 64 (the watchdog is 6 bits wide).
module div_ctrl #(
    parameter int unsigned TIMEOUT = 40
) (
    input  logic        div_clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_signed,
    input  logic [31:0] req_x,
    input  logic [31:0] req_y,
    output logic        req_ready,
    input  logic        flush,
    output logic        div_start,
    output logic        div_signed_o,
    output logic [31:0] div_x,
    output logic [31:0] div_y,
    input  logic [31:0] div_s,
    input  logic [31:0] div_r,
    input  logic        div_complete,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] res_quo,
    output logic [31:0] res_rem,
    output logic        res_err,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t     state;
    state_t     state_nx;
    logic [5:0] wd;

    // Register load strobes decided by the next-state logic.
    logic       ld_op;       // latch operands for the divider
    logic       ld_zero;     // divide-by-zero result
    logic       ld_res;      // divider result
    logic       ld_timeout;  // watchdog abort result

    assign req_ready = (state == IDLE) && !flush && reset;
    assign div_start = (state == RUN);
    assign res_valid = (state == DONE);
    assign busy      = (state != IDLE);

    always_comb begin
        state_nx   = state;
        ld_op      = 1'b0;
        ld_zero    = 1'b0;
        ld_res     = 1'b0;
        ld_timeout = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid && req_ready) begin
                    if (req_y != '0) begin
                        ld_op    = 1'b1;
                        state_nx = RUN;
                    end else begin
                        ld_zero  = 1'b1;
                        state_nx = DONE;
                    end
                end
            end
            RUN: begin
                // Flush wins over a completion arriving in the same cycle.
                if (flush) begin
                    state_nx = IDLE;
                end else if (div_complete) begin
                    ld_res   = 1'b1;
                    state_nx = DONE;
                end else if (wd == 6'(TIMEOUT - 1)) begin
                    ld_timeout = 1'b1;
                    state_nx   = DONE;
                end
            end
            DONE: begin
                if (flush || res_ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge div_clk) begin
        if (!reset) begin
            state        <= IDLE;
            wd           <= '0;
            div_x        <= '0;
            div_y        <= '0;
            div_signed_o <= 1'b0;
            res_quo      <= '0;
            res_rem      <= '0;
            res_err      <= 1'b0;
        end else begin
            state <= state_nx;
            // Counts RUN cycles; restarts from 0 on every entry to RUN.
            if (state == RUN && state_nx == RUN) begin
                wd <= wd + 6'd1;
            end else begin
                wd <= '0;
            end
            if (ld_op) begin
                div_x        <= req_x;
                div_y        <= req_y;
                div_signed_o <= req_signed;
            end
            if (ld_zero) begin
                res_quo <= '1;
                res_rem <= req_x;
                res_err <= 1'b0;
            end else if (ld_res) begin
                res_quo <= div_s;
                res_rem <= div_r;
                res_err <= 1'b0;
            end else if (ld_timeout) begin
                res_quo <= '0;
                res_rem <= '0;
                res_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_div_ctrl.sv
// tb_div_ctrl: self-checking bench for div_ctrl. A behavioural divider
// (asserts completion in the 34th cycle of a held start, unless stuck)
// drives the divider-side inputs; expected results come from plain
// arithmetic on the request operands.
module tb_div_ctrl;

    localparam int unsigned TIMEOUT = 40;

    logic        div_clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_signed;
    logic [31:0] req_x;
    logic [31:0] req_y;
    logic        req_ready;
    logic        flush;
    logic        div_start;
    logic        div_signed_o;
    logic [31:0] div_x;
    logic [31:0] div_y;
    logic [31:0] div_s;
    logic [31:0] div_r;
    logic        div_complete;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_quo;
    logic [31:0] res_rem;
    logic        res_err;
    logic        busy;

    int checks = 0;
    int errors = 0;

    always #5 div_clk = ~div_clk;

    div_ctrl #(.TIMEOUT(TIMEOUT)) dut (
        .div_clk      (div_clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_signed   (req_signed),
        .req_x        (req_x),
        .req_y        (req_y),
        .req_ready    (req_ready),
        .flush        (flush),
        .div_start    (div_start),
        .div_signed_o (div_signed_o),
        .div_x        (div_x),
        .div_y        (div_y),
        .div_s        (div_s),
        .div_r        (div_r),
        .div_complete (div_complete),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_quo      (res_quo),
        .res_rem      (res_rem),
        .res_err      (res_err),
        .busy         (busy)
    );

    // Architectural DIV/DIVU result: {quotient, remainder}.
    function automatic logic [63:0] ref_div(input logic [31:0] x, input logic [31:0] y,
                                            input logic sgn);
        int sx;
        int sy;
        logic [31:0] q;
        logic [31:0] r;
        if (y == 32'd0) return {32'hFFFF_FFFF, x};
        if (sgn) begin
            if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'h8000_0000, 32'd0};
            sx = x;
            sy = y;
            q = 32'(sx / sy);
            r = 32'(sx % sy);
        end else begin
            q = x / y;
            r = x % y;
        end
        return {q, r};
    endfunction

    // Behavioural divider: completes in the 34th cycle of a held start.
    logic       stuck = 1'b0;
    logic [5:0] dcnt;
    always_ff @(posedge div_clk) begin
        if (!div_start) dcnt <= '0;
        else            dcnt <= dcnt + 6'd1;
    end
    assign div_complete = div_start && (dcnt == 6'd33) && !stuck;
    assign {div_s, div_r} = ref_div(div_x, div_y, div_signed_o);

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // One complete request/response transaction.
    task automatic run_op(input logic [31:0] x, input logic [31:0] y, input logic sgn,
                          input int hold, input logic stk);
        logic [63:0] e;
        int exp_lat;
        int lat;
        int starts;
        if (stk && y != 32'd0) begin
            e = 64'd0;
            exp_lat = TIMEOUT;
        end else begin
            e = ref_div(x, y, sgn);
            exp_lat = (y == 32'd0) ? 0 : 34;
        end
        stuck = stk;
        @(negedge div_clk);
        req_valid = 1'b1; req_x = x; req_y = y; req_signed = sgn;
        #1 check("req_ready", req_ready, 1);
        @(posedge div_clk); #1;
        req_valid = 1'b0; req_x = $urandom; req_y = $urandom; req_signed = 1'($urandom);
        if (y != 32'd0) begin
            check("div_x", div_x, x);
            check("div_y", div_y, y);
            check("div_signed", div_signed_o, sgn);
        end
        lat = 0;
        starts = 0;
        while (!res_valid && lat < 200) begin
            if (div_start) starts++;
            @(posedge div_clk); #1;
            lat++;
        end
        check("latency", lat, exp_lat);
        check("start_cycles", starts, (y == 32'd0) ? 0 : exp_lat);
        check("start_low_done", div_start, 0);
        check("quo", res_quo, e[63:32]);
        check("rem", res_rem, e[31:0]);
        check("err", res_err, (stk && y != 32'd0) ? 1 : 0);
        for (int i = 0; i < hold; i++) begin
            @(posedge div_clk); #1;
            check("hold_valid", res_valid, 1);
            check("hold_quo", res_quo, e[63:32]);
            check("hold_rem", res_rem, e[31:0]);
            check("hold_req_ready", req_ready, 0);
        end
        @(negedge div_clk); res_ready = 1'b1;
        @(posedge div_clk); #1; res_ready = 1'b0;
        check("idle_after", busy, 0);
        check("gap_start_low", div_start, 0);
        check("valid_after", res_valid, 0);
        stuck = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    initial begin
        reset = 1'b0; req_valid = 1'b0; req_signed = 1'b0; req_x = '0; req_y = '0;
        flush = 1'b0; res_ready = 1'b0;
        repeat (3) @(posedge div_clk);
        #1;
        check("rst_req_ready", req_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_start", div_start, 0);
        check("rst_valid", res_valid, 0);
        check("rst_quo", res_quo, 0);
        @(negedge div_clk); reset = 1'b1;

        // Directed cases
        run_op(32'd100, 32'd7, 1'b0, 0, 1'b0);
        run_op(32'hFFFF_FFF9, 32'd2, 1'b1, 0, 1'b0);
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0, 1'b0);
        run_op(32'h1234, 32'd0, 1'b0, 0, 1'b0);

        // Flush on the 10th RUN cycle
        @(negedge div_clk);
        req_valid = 1'b1; req_x = 32'd1000; req_y = 32'd3; req_signed = 1'b0;
        @(posedge div_clk); #1; req_valid = 1'b0;
        repeat (9) @(posedge div_clk);
        @(negedge div_clk); flush = 1'b1;
        @(posedge div_clk); #1; flush = 1'b0;
        check("flush_start", div_start, 0);
        check("flush_busy", busy, 0);
        for (int i = 0; i < 40; i++) begin
            @(posedge div_clk); #1;
            check("flush_no_valid", res_valid, 0);
        end
        run_op(32'd9, 32'd4, 1'b0, 0, 1'b0);

        // Held result, then back-to-back requests
        run_op(32'd12345, 32'd100, 1'b0, 5, 1'b0);
        run_op(32'd77, 32'd5, 1'b0, 0, 1'b0);

        // Flush in IDLE with a request present
        @(negedge div_clk); req_valid = 1'b1; req_y = 32'd5; flush = 1'b1;
        #1 check("flush_idle_ready", req_ready, 0);
        @(posedge div_clk); #1; req_valid = 1'b0; flush = 1'b0;
        check("flush_idle_busy", busy, 0);

        // Flush overriding res_ready in DONE
        @(negedge div_clk); req_valid = 1'b1; req_x = 32'd8; req_y = 32'd0;
        @(posedge div_clk); #1; req_valid = 1'b0;
        check("zero_valid", res_valid, 1);
        @(negedge div_clk); flush = 1'b1; res_ready = 1'b1;
        @(posedge div_clk); #1; flush = 1'b0; res_ready = 1'b0;
        check("flush_done_valid", res_valid, 0);

        // Watchdog timeout, then reset mid-RUN
        run_op(32'd500, 32'd9, 1'b0, 2, 1'b1);
        @(negedge div_clk);
        req_valid = 1'b1; req_x = 32'hDEAD_BEEF; req_y = 32'd17; req_signed = 1'b1;
        @(posedge div_clk); #1;
        repeat (5) @(posedge div_clk);
        @(negedge div_clk); reset = 1'b0;
        #1 check("rst_mid_ready", req_ready, 0);
        @(posedge div_clk); #1;
        check("rst_mid_busy", busy, 0);
        check("rst_mid_start", div_start, 0);
        check("rst_mid_valid", res_valid, 0);
        check("rst_mid_err", res_err, 0);
        check("rst_mid_quo", res_quo, 0);
        check("rst_mid_rem", res_rem, 0);
        check("rst_mid_x", div_x, 0);
        check("rst_mid_y", div_y, 0);
        check("rst_mid_sgn", div_signed_o, 0);
        @(negedge div_clk); reset = 1'b1; req_valid = 1'b0;
        run_op(32'd1000, 32'd33, 1'b0, 0, 1'b0);

        // Randomized operations
        for (int n = 0; n < 25; n++) begin
            logic [31:0] rx;
            logic [31:0] ry;
            rx = $urandom;
            case ($urandom_range(0, 5))
                0:       ry = 32'd0;
                1:       ry = 32'hFFFF_FFFF;
                2:       ry = 32'($urandom_range(1, 20));
                default: ry = $urandom;
            endcase
            run_op(rx, ry, 1'($urandom), int'($urandom_range(0, 3)),
                   ($urandom_range(0, 9) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
